pacman_input_ctrl: RTL and testbench
====================================

PACMAN_INPUT_CTRL -- requirements
Module: pacman_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable clock cycles required to accept a button change (5 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports btnL, btnR, btnU, btnD, input, 1 each, raw asynchronous push-buttons, 1 = pressed.
REQ-005 SHALL have port start, input, 1, level request to begin play.
REQ-006 SHALL have port ack, input, 1, level acknowledge to leave end-of-game.
REQ-007 SHALL have ports win, lose, input, 1 each, end-of-game flags from game logic.
REQ-008 SHALL have ports Left, Right, Up, Down, output, 1 each, registered held heading for the movement stage, at most one high.
REQ-009 SHALL have ports qIdle, qRun, qHalt, output, 1 each, registered one-hot state indicators.

Function
REQ-010 SHALL pass each raw button through a two-flop synchronizer before any other use.
REQ-011 SHALL keep one debounced level per button, reset 0.
REQ-012 SHALL keep one counter per button, reset 0, cleared whenever synchronized value equals debounced level.
REQ-013 SHALL increment that counter each cycle synchronized value differs from debounced level, and on the edge where it would reach DEBOUNCE_CYCLES SHALL copy synchronized value into debounced level and clear counter.
REQ-014 SHALL size counters as ceil(log2(DEBOUNCE_CYCLES+1)) bits; counter never wraps.
REQ-015 SHALL derive a one-cycle press pulse per button on debounced 0->1 transition.
REQ-016 SHALL implement FSM IDLE, RUN, HALT; reset state IDLE.
REQ-017 IDLE: start=1 -> RUN; heading cleared on entry to RUN.
REQ-018 RUN: win=1 or lose=1 (either or both) -> HALT; takes priority over any press pulse in same cycle.
REQ-019 HALT: ack=1 -> IDLE; start ignored in HALT; ack ignored in IDLE and RUN.
REQ-020 In RUN, exactly one press pulse in a cycle SHALL load heading with that direction on the next edge; reversal allowed.
REQ-021 In RUN, two or more simultaneous press pulses SHALL leave heading unchanged.
REQ-022 Heading SHALL persist after button release until a new valid press, state exit, or reset.
REQ-023 Left/Right/Up/Down SHALL equal heading in RUN and SHALL be all 0 in IDLE and HALT, registered (no combinational path from any input).
REQ-024 Latency raw press to heading output: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle, with button stable throughout.
REQ-025 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no press pulse.
REQ-026 Debouncers SHALL run in all FSM states; a button held across IDLE->RUN SHALL not produce a press pulse.

Reset
REQ-027 Assertion of reset at any time SHALL asynchronously force IDLE, heading none, all debounced levels, counters and synchronizer flops 0, outputs Left/Right/Up/Down 0, qIdle 1, qRun 0, qHalt 0.
REQ-028 After deassertion, first transition SHALL occur no earlier than the first clk edge with reset low.

Structure
REQ-029 State encoding (IDLE, RUN, HALT) and 4-bit direction one-hot constants (L,U,R,D bit order) SHALL live in shared package pacman_pkg.
REQ-030 Synchronizer plus debounce counter SHALL be sub-module button_debouncer, instantiated four times, parameter DEBOUNCE_CYCLES passed through.
REQ-031 FSM and heading register SHALL reside in pacman_input_ctrl top.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset, start=1 one cycle, btnR held 10 cycles -> qRun=1, Right=1 exactly 7 cycles after btnR rises, stays 1 after release.
REQ-033 In RUN, btnU pulse 3 cycles -> no change to heading; Right remains 1.
REQ-034 In RUN heading Right, btnL and btnD pressed same edge, held 10 cycles -> heading stays Right; then btnD released, btnL re-pressed -> Left=1.
REQ-035 In RUN heading Left, lose=1 same cycle as btnU press pulse -> next cycle qHalt=1, all directions 0; start=1 -> stays HALT; ack=1 -> qIdle=1.
REQ-036 btnD held through IDLE->RUN transition -> Down stays 0 until released and re-pressed.
REQ-037 reset pulsed mid-debounce and in RUN with heading Up -> outputs immediately qIdle=1, all directions 0, no press pulse after deassertion from pre-reset count.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared state encoding and heading constants for the Pac-Man input controller.
package pacman_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Heading bit order: [0]=Left, [1]=Up, [2]=Right, [3]=Down
  localparam logic [3:0] DIR_NONE = 4'b0000;
  localparam logic [3:0] DIR_L    = 4'b0001;
  localparam logic [3:0] DIR_U    = 4'b0010;
  localparam logic [3:0] DIR_R    = 4'b0100;
  localparam logic [3:0] DIR_D    = 4'b1000;

  function automatic logic is_single_dir(input logic [3:0] dirs);
    return (dirs != DIR_NONE) && ((dirs & (dirs - 4'd1)) == DIR_NONE);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stable-run debounce counter; emits a
// single-cycle pulse when the debounced level rises.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: synchronizer; counter tracks how long p1 has disagreed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      level_d <= level;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/pacman_input_ctrl.sv
// Debounced four-way joystick front end with IDLE/RUN/HALT game-state FSM and
// a held heading register feeding the movement stage.
module pacman_input_ctrl
  import pacman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnL,
  input  logic btnR,
  input  logic btnU,
  input  logic btnD,
  input  logic start,
  input  logic ack,
  input  logic win,
  input  logic lose,
  output logic Left,
  output logic Right,
  output logic Up,
  output logic Down,
  output logic qIdle,
  output logic qRun,
  output logic qHalt
);

  logic [3:0] press;
  state_t     state;
  state_t     state_nx;
  logic [3:0] heading;
  logic [3:0] heading_nx;
  logic [3:0] dir_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk(clk), .reset(reset), .btn(btnL), .press(press[0]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (
    .clk(clk), .reset(reset), .btn(btnU), .press(press[1]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk(clk), .reset(reset), .btn(btnR), .press(press[2]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .clk(clk), .reset(reset), .btn(btnD), .press(press[3]));

  // End-of-game beats any simultaneous press; ambiguous multi-press is ignored
  always_comb begin
    state_nx   = state;
    heading_nx = heading;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx   = ST_RUN;
          heading_nx = DIR_NONE;
        end
      end
      ST_RUN: begin
        if (win || lose) begin
          state_nx   = ST_HALT;
          heading_nx = DIR_NONE;
        end else if (is_single_dir(press)) begin
          heading_nx = press;
        end
      end
      ST_HALT: begin
        if (ack) state_nx = ST_IDLE;
      end
      default: begin
        state_nx   = ST_IDLE;
        heading_nx = DIR_NONE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they align with state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      heading <= DIR_NONE;
      dir_q   <= DIR_NONE;
      qIdle   <= 1'b1;
      qRun    <= 1'b0;
      qHalt   <= 1'b0;
    end else begin
      state   <= state_nx;
      heading <= heading_nx;
      dir_q   <= (state_nx == ST_RUN) ? heading_nx : DIR_NONE;
      qIdle   <= (state_nx == ST_IDLE);
      qRun    <= (state_nx == ST_RUN);
      qHalt   <= (state_nx == ST_HALT);
    end
  end

  assign Left  = dir_q[0];
  assign Up    = dir_q[1];
  assign Right = dir_q[2];
  assign Down  = dir_q[3];

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Directed bench for pacman_input_ctrl with a cycle-level reference model.
module tb_pacman_input_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset;
  logic btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0;
  logic start = 1'b0, ack = 1'b0, win = 1'b0, lose = 1'b0;
  logic Left, Right, Up, Down, qIdle, qRun, qHalt;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  pacman_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset),
    .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
    .start(start), .ack(ack), .win(win), .lose(lose),
    .Left(Left), .Right(Right), .Up(Up), .Down(Down),
    .qIdle(qIdle), .qRun(qRun), .qHalt(qHalt));

  always #5 clk = ~clk;

  // Reference model: raw -> 2-sample delay -> stable-run acceptance -> rising-edge pulse
  logic [3:0] raw;
  assign raw = {btnD, btnR, btnU, btnL};

  int         m_run[4] = '{0, 0, 0, 0};
  bit         m_deb[4] = '{0, 0, 0, 0};
  bit         m_debp[4] = '{0, 0, 0, 0};
  bit         m_d1[4] = '{0, 0, 0, 0};
  bit         m_d2[4] = '{0, 0, 0, 0};
  int         m_state = 0;  // 0 idle, 1 run, 2 halt
  bit [3:0]   m_head = 4'b0;
  bit [3:0]   m_pulse;
  int         m_npress;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        m_run[b] = 0; m_deb[b] = 0; m_debp[b] = 0; m_d1[b] = 0; m_d2[b] = 0;
      end
      m_state = 0;
      m_head  = 4'b0;
    end else begin
      m_npress = 0;
      for (int b = 0; b < 4; b++) begin
        m_pulse[b] = m_deb[b] && !m_debp[b];
        if (m_pulse[b]) m_npress++;
      end
      if (m_state == 0) begin
        if (start) begin m_state = 1; m_head = 4'b0; end
      end else if (m_state == 1) begin
        if (win || lose) begin m_state = 2; m_head = 4'b0; end
        else if (m_npress == 1) m_head = m_pulse;
      end else begin
        if (ack) m_state = 0;
      end
      for (int b = 0; b < 4; b++) begin
        m_debp[b] = m_deb[b];
        if (m_d2[b] != m_deb[b]) begin
          if (m_run[b] + 1 == DB) begin m_deb[b] = m_d2[b]; m_run[b] = 0; end
          else m_run[b] = m_run[b] + 1;
        end else begin
          m_run[b] = 0;
        end
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
      end
    end
  end

  function automatic logic [6:0] model_vec();
    logic [3:0] d;
    d = (m_state == 1) ? m_head : 4'b0;
    return {m_state == 0, m_state == 1, m_state == 2, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en)
      check("model", 32'({qIdle, qRun, qHalt, Down, Right, Up, Left}), 32'(model_vec()));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    #2 cmp_en = 1'b1;
    tick(2);
    check("reset_state", 32'({qIdle, qRun, qHalt, Down, Right, Up, Left}), 32'h40);
    reset = 1'b0;
    tick(1);

    // Start play, then hold Right: heading appears 7 cycles after the press
    start = 1'b1; tick(1); start = 1'b0;
    check("run_entered", 32'({qIdle, qRun, qHalt}), 32'b010);
    btnR = 1'b1;
    tick(6);
    check("right_at_6", 32'(Right), 32'd0);
    tick(1);
    check("right_at_7", 32'(Right), 32'd1);
    tick(3); btnR = 1'b0; tick(8);
    check("right_held", 32'({Down, Right, Up, Left}), 32'b0100);

    // Short glitch on Up is rejected
    btnU = 1'b1; tick(3); btnU = 1'b0; tick(8);
    check("glitch_up", 32'({Down, Right, Up, Left}), 32'b0100);

    // Simultaneous Left+Down presses are ambiguous; a clean Left re-press wins
    btnL = 1'b1; btnD = 1'b1; tick(10);
    check("dual_press", 32'({Down, Right, Up, Left}), 32'b0100);
    btnD = 1'b0; btnL = 1'b0; tick(8);
    btnL = 1'b1; tick(7);
    check("left_repress", 32'({Down, Right, Up, Left}), 32'b0001);
    btnL = 1'b0; tick(8);

    // lose coincides with an Up press pulse: HALT wins
    btnU = 1'b1; tick(6);
    lose = 1'b1; tick(1); lose = 1'b0;
    check("lose_halt", 32'({qIdle, qRun, qHalt, Down, Right, Up, Left}), 32'h10);
    start = 1'b1; tick(2); start = 1'b0;
    check("start_in_halt", 32'({qIdle, qRun, qHalt}), 32'b001);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("ack_idle", 32'({qIdle, qRun, qHalt}), 32'b100);
    btnU = 1'b0; tick(8);

    // Down held across IDLE->RUN produces no press
    btnD = 1'b1; tick(10);
    start = 1'b1; tick(1); start = 1'b0; tick(5);
    check("held_down", 32'({qRun, Down}), 32'b10);
    btnD = 1'b0; tick(8);
    check("down_release", 32'(Down), 32'd0);
    btnD = 1'b1; tick(7);
    check("down_repress", 32'(Down), 32'd1);
    btnD = 1'b0; tick(8);

    // Heading Up, then reset mid-debounce of Left
    btnU = 1'b1; tick(7);
    check("up_heading", 32'({Down, Right, Up, Left}), 32'b0010);
    btnU = 1'b0;
    btnL = 1'b1; tick(4);
    #3 reset = 1'b1;
    #1 check("async_reset", 32'({qIdle, qRun, qHalt, Down, Right, Up, Left}), 32'h40);
    tick(1); reset = 1'b0;
    start = 1'b1; tick(1); start = 1'b0; tick(5);
    check("no_stale_count", 32'(Left), 32'd0);
    tick(1);
    check("fresh_debounce", 32'({qRun, Left}), 32'b11);

    // win alone ends the game
    win = 1'b1; tick(1); win = 1'b0;
    check("win_halt", 32'({qIdle, qRun, qHalt, Down, Right, Up, Left}), 32'h10);
    btnL = 1'b0; tick(8);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
